// File: rtl/prio_encoder_8to3_seq_if.sv
// Request/code bus of the sequential priority encoder.
// master drives requests and accepts codes; slave is the encoder itself.
interface prio_encoder_8to3_seq_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic         code_ready;
    logic         code_valid;
    logic [W-1:0] code;
    logic [N-1:0] pending;
    logic         merged;
    logic         busy;

    modport master (
        output req, code_ready,
        input  code_valid, code, pending, merged, busy
    );

    modport slave (
        input  req, code_ready,
        output code_valid, code, pending, merged, busy
    );
endinterface

// File: rtl/prio_encoder_8to3_seq.sv
// Sequential priority encoder: sticky pending vector drained one binary
// index per handshake, in strict priority order.
module prio_encoder_8to3_seq #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    prio_encoder_8to3_seq_if.slave bus
);
    localparam int W = $clog2(N);

    logic [N-1:0] pending_q, pending_d;
    logic         code_valid_q, code_valid_d;
    logic [W-1:0] code_q, code_d;
    logic         merged_q, merged_d;

    logic         ld;
    logic [W-1:0] win_idx;
    logic [N-1:0] gnt;

    // Winner is picked from the registered vector only; req never bypasses.
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = LSB_FIRST ? i : (N - 1 - i);
            if (pending_q[j]) win_idx = W'(j);
        end
    end

    assign ld  = (!code_valid_q || bus.code_ready) && (pending_q != '0);
    assign gnt = ld ? (N'(1) << win_idx) : '0;

    always_comb begin
        // Set wins over the clear of the bit granted this cycle.
        pending_d    = (pending_q & ~gnt) | bus.req;
        merged_d     = |(bus.req & pending_q & ~gnt);
        code_valid_d = code_valid_q;
        code_d       = code_q;
        if (ld) begin
            code_valid_d = 1'b1;
            code_d       = win_idx;
        end else if (bus.code_ready) begin
            code_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            code_valid_q <= 1'b0;
            code_q       <= '0;
            merged_q     <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            merged_q     <= merged_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code       = code_q;
    assign bus.merged     = merged_q;
    assign bus.busy       = (|pending_q) | code_valid_q;
endmodule

// File: tb/tb_prio_encoder_8to3_seq.sv
// Directed bench: LSB-first instance for most cases, MSB-first instance for priority direction.
module tb_prio_encoder_8to3_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    prio_encoder_8to3_seq_if #(.N(8)) bl ();
    prio_encoder_8to3_seq_if #(.N(8)) bm ();

    prio_encoder_8to3_seq #(.N(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(bl));
    prio_encoder_8to3_seq #(.N(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(bm));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [2:0] exp3 [4];
        bit [2:0] exp6 [3];
        bl.req = '0; bl.code_ready = 1'b0;
        bm.req = '0; bm.code_ready = 1'b1;

        // reset state
        #2;
        chk("rst_pending", 32'(bl.pending), 32'h0);
        chk("rst_valid", 32'(bl.code_valid), 32'h0);
        chk("rst_busy", 32'(bl.busy), 32'h0);
        tick();
        rst = 1'b0;

        // 1: async reset mid-stream with pending=A5, code_valid=1
        bl.req = 8'h01; tick();
        bl.req = 8'hA5; tick();
        tick();
        bl.req = 8'h00;
        chk("t1_pending", 32'(bl.pending), 32'hA5);
        chk("t1_valid", 32'(bl.code_valid), 32'h1);
        chk("t1_merged", 32'(bl.merged), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_pending", 32'(bl.pending), 32'h0);
        chk("t1_rst_valid", 32'(bl.code_valid), 32'h0);
        chk("t1_rst_code", 32'(bl.code), 32'h0);
        chk("t1_rst_merged", 32'(bl.merged), 32'h0);
        #1 rst = 1'b0;

        // 2: single request, two-edge latency
        bl.code_ready = 1'b1;
        bl.req = 8'h10; tick();
        bl.req = 8'h00;
        chk("t2_pend", 32'(bl.pending), 32'h10);
        chk("t2_early_valid", 32'(bl.code_valid), 32'h0);
        tick();
        chk("t2_valid", 32'(bl.code_valid), 32'h1);
        chk("t2_code", 32'(bl.code), 32'h4);
        chk("t2_busy", 32'(bl.busy), 32'h1);
        tick();
        chk("t2_drop_valid", 32'(bl.code_valid), 32'h0);
        chk("t2_idle_busy", 32'(bl.busy), 32'h0);
        chk("t2_code_hold", 32'(bl.code), 32'h4);

        // 3: burst 1001_0110 -> 1,2,4,7 back to back
        exp3 = '{3'd1, 3'd2, 3'd4, 3'd7};
        bl.req = 8'b1001_0110; tick();
        bl.req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3_valid%0d", i), 32'(bl.code_valid), 32'h1);
            chk($sformatf("t3_code%0d", i), 32'(bl.code), 32'(exp3[i]));
        end
        chk("t3_pend_end", 32'(bl.pending), 32'h0);
        tick();
        chk("t3_valid_end", 32'(bl.code_valid), 32'h0);

        // 4: backpressure holds code 2 stable
        bl.code_ready = 1'b0;
        bl.req = 8'h0C; tick();
        bl.req = 8'h00; tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t4_hold_code%0d", i), 32'(bl.code), 32'h2);
            chk($sformatf("t4_hold_valid%0d", i), 32'(bl.code_valid), 32'h1);
            chk($sformatf("t4_hold_pend%0d", i), 32'(bl.pending), 32'h08);
        end
        bl.code_ready = 1'b1; tick();
        chk("t4_next_code", 32'(bl.code), 32'h3);
        chk("t4_next_pend", 32'(bl.pending), 32'h0);
        tick();
        chk("t4_drained", 32'(bl.code_valid), 32'h0);

        // 5a: coalesce bit 5 while output stalled
        bl.req = 8'h01; tick();
        bl.req = 8'h00; tick();
        bl.code_ready = 1'b0;
        bl.req = 8'h20; tick();
        chk("t5_merged0", 32'(bl.merged), 32'h0);
        tick();
        chk("t5_merged1", 32'(bl.merged), 32'h1);
        tick();
        chk("t5_merged2", 32'(bl.merged), 32'h1);
        bl.req = 8'h00; tick();
        chk("t5_merged3", 32'(bl.merged), 32'h0);
        chk("t5_stall_code", 32'(bl.code), 32'h0);
        bl.code_ready = 1'b1; tick();
        chk("t5_code5", 32'(bl.code), 32'h5);
        chk("t5_valid5", 32'(bl.code_valid), 32'h1);
        tick();
        chk("t5_once", 32'(bl.code_valid), 32'h0);

        // 5b: set wins on the grant cycle -> code 2 twice
        bl.req = 8'h04; tick();
        tick();
        bl.req = 8'h00;
        chk("t5_sw_code_a", 32'(bl.code), 32'h2);
        chk("t5_sw_pend", 32'(bl.pending), 32'h04);
        chk("t5_sw_merged", 32'(bl.merged), 32'h0);
        tick();
        chk("t5_sw_code_b", 32'(bl.code), 32'h2);
        chk("t5_sw_valid_b", 32'(bl.code_valid), 32'h1);
        tick();
        chk("t5_sw_end", 32'(bl.code_valid), 32'h0);

        // 6: MSB-first instance, 0100_0011 -> 6,1,0
        exp6 = '{3'd6, 3'd1, 3'd0};
        bm.req = 8'b0100_0011; tick();
        bm.req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_valid%0d", i), 32'(bm.code_valid), 32'h1);
            chk($sformatf("t6_code%0d", i), 32'(bm.code), 32'(exp6[i]));
        end
        tick();
        chk("t6_end", 32'(bm.busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
